stream_sample_player: RTL

Streaming stimulus source for the adaptive filter datapath: holds up to DEPTH fixed-point samples loaded through a simple write port and plays them out as a valid-qualified stream (m_tdata/m_tvalid) matching the filter's s_tdata/s_tvalid input. It is the transmitting end of the filter input stream. It replaces file-driven stimulus, so filter characterisation can run on hardware with programmable length, inter-sample gap and looping.

---
 rtl/stream_player_pkg.sv | 15 +
 rtl/sample_ram.sv | 39 +++
 rtl/stream_sample_player.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/stream_player_pkg.sv
// Shared types and default parameters for the stream sample player.
package stream_player_pkg;

    localparam int DEF_WORDLENGTH = 14;
    localparam int DEF_DEPTH      = 128;
    localparam int DEF_GAP_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EMIT = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample memory: one write port, one synchronous read port
// with a single cycle of read latency.
module sample_ram #(
    parameter int WIDTH      = 14,
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Memory array write port (contents intentionally not reset).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/stream_sample_player.sv
// Plays a programmable-length sample table out as a valid-qualified stream,
// with optional inter-sample gap and looping.
module stream_sample_player
    import stream_player_pkg::*;
#(
    parameter int WORDLENGTH = DEF_WORDLENGTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int GAP_WIDTH  = DEF_GAP_WIDTH
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WORDLENGTH-1:0]    wr_data,
    input  logic [$clog2(DEPTH):0]   len,
    input  logic [GAP_WIDTH-1:0]     gap,
    input  logic                     loop,
    input  logic                     start,
    input  logic                     stop,
    output logic [WORDLENGTH-1:0]    m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_LEN = LW'(DEPTH);

    state_t                state_r, state_s;
    logic [AW-1:0]         ptr_r, ptr_s, ptr_inc_s;
    logic [LW-1:0]         len_r, len_s;
    logic [GAP_WIDTH-1:0]  gap_r, gap_s, gap_cnt_r, gap_cnt_s;
    logic                  loop_r, loop_s;
    logic [WORDLENGTH-1:0] tdata_r, tdata_s;
    logic                  tvalid_r, tvalid_s;
    logic                  tlast_r, tlast_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  last_s;
    logic                  wr_en_s;
    logic                  rd_en_s;
    logic [AW-1:0]         rd_addr_s;
    logic [WORDLENGTH-1:0] rd_data_s;

    assign wr_en_s   = wr_en && (state_r == IDLE);
    assign last_s    = ({1'b0, ptr_r} == (len_r - LW'(1)));
    assign ptr_inc_s = last_s ? {AW{1'b0}} : (ptr_r + AW'(1));

    sample_ram #(
        .WIDTH      (WORDLENGTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk     (clk),
        .srst    (srst),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en_s),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // Next-state, pointer, gap counter and output-register logic.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        len_s     = len_r;
        gap_s     = gap_r;
        loop_s    = loop_r;
        gap_cnt_s = gap_cnt_r;
        tdata_s   = tdata_r;
        tvalid_s  = 1'b0;
        tlast_s   = 1'b0;
        done_s    = 1'b0;
        rd_en_s   = 1'b0;
        rd_addr_s = ptr_r;
        case (state_r)
            IDLE: begin
                if (start && !stop && (len != {LW{1'b0}})) begin
                    len_s   = (len > DEPTH_LEN) ? DEPTH_LEN : len;
                    gap_s   = gap;
                    loop_s  = loop;
                    ptr_s   = {AW{1'b0}};
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (stop) begin
                    state_s = IDLE;
                end else begin
                    rd_en_s = 1'b1;
                    state_s = EMIT;
                end
            end
            EMIT: begin
                if (stop) begin
                    state_s = IDLE;
                end else begin
                    tdata_s  = rd_data_s;
                    tvalid_s = 1'b1;
                    tlast_s  = last_s;
                    ptr_s    = ptr_inc_s;
                    if (last_s && !loop_r) begin
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end else if (gap_r == {GAP_WIDTH{1'b0}}) begin
                        // Read of the next sample overlaps this emission.
                        rd_en_s   = 1'b1;
                        rd_addr_s = ptr_inc_s;
                        state_s   = EMIT;
                    end else begin
                        gap_cnt_s = gap_r - GAP_WIDTH'(1);
                        state_s   = GAP;
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    state_s = IDLE;
                end else if (gap_cnt_r == {GAP_WIDTH{1'b0}}) begin
                    // Last idle cycle doubles as the read cycle.
                    rd_en_s = 1'b1;
                    state_s = EMIT;
                end else begin
                    gap_cnt_s = gap_cnt_r - GAP_WIDTH'(1);
                    state_s   = GAP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State, control and output registers.
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state_r   <= IDLE;
            ptr_r     <= {AW{1'b0}};
            len_r     <= {LW{1'b0}};
            gap_r     <= {GAP_WIDTH{1'b0}};
            loop_r    <= 1'b0;
            gap_cnt_r <= {GAP_WIDTH{1'b0}};
            tdata_r   <= {WORDLENGTH{1'b0}};
            tvalid_r  <= 1'b0;
            tlast_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            len_r     <= len_s;
            gap_r     <= gap_s;
            loop_r    <= loop_s;
            gap_cnt_r <= gap_cnt_s;
            tdata_r   <= tdata_s;
            tvalid_r  <= tvalid_s;
            tlast_r   <= tlast_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign m_tdata  = tdata_r;
    assign m_tvalid = tvalid_r;
    assign m_tlast  = tlast_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule
